// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point format types and helpers.
// Default widths, bias, operand/flag structs, INF/ZERO builders.
package fp_pkg;

   localparam int EXP_W_D  = 5;
   localparam int MAN_W_D  = 10;
   localparam int FP_MAX_W = 64;

   typedef struct packed {
      logic               sign;
      logic [EXP_W_D-1:0] exp;
      logic [MAN_W_D-1:0] man;
   } fp_unpacked_t;

   typedef struct packed {
      logic ovf;
      logic udf;
      logic inexact;
   } fp_flags_t;

   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Builders return a FP_MAX_W-wide word; callers size-cast to FP_W.
   function automatic logic [FP_MAX_W-1:0] fp_zero(
      input int   exp_w,
      input int   man_w,
      input logic sign
   );
      return {{(FP_MAX_W-1){1'b0}}, sign} << (exp_w + man_w);
   endfunction

   function automatic logic [FP_MAX_W-1:0] fp_inf(
      input int   exp_w,
      input int   man_w,
      input logic sign
   );
      logic [FP_MAX_W-1:0] one;
      one = {{(FP_MAX_W-1){1'b0}}, 1'b1};
      return fp_zero(exp_w, man_w, sign)
           | (((one << exp_w) - one) << man_w);
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalise, round, range-check and pack a raw product.
// In: sign, zero, exp_sum (signed), prod. Out: res word, flags. Macro FP_MUL_RNE_EN selects RNE.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_D,
   parameter int MAN_W = MAN_W_D
) (
   input  logic                      sign,
   input  logic                      zero,
   input  logic signed [EXP_W+1:0]   exp_sum,
   input  logic [2*MAN_W+1:0]        prod,
   output logic [EXP_W+MAN_W:0]      res,
   output fp_flags_t                 flags
);
   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam int E_W  = EXP_W + 2;
   localparam int P_W  = 2 * MAN_W + 2;
   localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

   logic [MAN_W-1:0]        man;
   logic [MAN_W:0]          rest;
   logic [MAN_W:0]          man_rnd;
   logic                    rnd_up;
   logic signed [E_W-1:0]   e_norm;
   logic signed [E_W-1:0]   e_fin;
   logic                    is_ovf;
   logic                    is_udf;

   always_comb begin
      // Product lies in [1,4): the MSB decides the one-bit normalise.
      man    = prod[P_W-1] ? prod[P_W-2 -: MAN_W]
                           : prod[P_W-3 -: MAN_W];
      rest   = prod[P_W-1] ? prod[MAN_W:0]
                           : {prod[MAN_W-1:0], 1'b0};
      e_norm = exp_sum + {{(E_W-1){1'b0}}, prod[P_W-1]};
`ifdef FP_MUL_RNE_EN
      // rest[MAN_W] is guard; lower bits fold into round/sticky.
      rnd_up = rest[MAN_W] & ((|rest[MAN_W-1:0]) | man[0]);
`else
      rnd_up = 1'b0;
`endif
      man_rnd = {1'b0, man} + {{MAN_W{1'b0}}, rnd_up};
      // Carry out means 10.00..0: mantissa field already 0.
      e_fin   = e_norm + {{(E_W-1){1'b0}}, man_rnd[MAN_W]};
      is_ovf  = !zero && (e_fin >= EXP_MAX);
      is_udf  = !zero && (e_fin[E_W-1] || (e_fin == '0));
   end

   always_comb begin
      flags = '0;
      res   = {sign, e_fin[EXP_W-1:0], man_rnd[MAN_W-1:0]};
      unique case (1'b1)
         zero: begin
            res = FP_W'(fp_zero(EXP_W, MAN_W, sign));
         end
         is_ovf: begin
            res           = FP_W'(fp_inf(EXP_W, MAN_W, sign));
            flags.ovf     = 1'b1;
            flags.inexact = 1'b1;
         end
         is_udf: begin
            res           = FP_W'(fp_zero(EXP_W, MAN_W, sign));
            flags.udf     = 1'b1;
            flags.inexact = 1'b1;
         end
         default: begin
            flags.inexact = |rest;
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage valid/ready FP multiplier (unpack, multiply, round/pack).
// Ports: CLK/RST, IN_* operand handshake + TAG_i, OUT_* result handshake, MUL_o/TAG_o/flags. Macro FP_MUL_RNE_EN.
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_D,
   parameter int MAN_W = MAN_W_D,
   parameter int TAG_W = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 IN_VALID_i,
   output logic                 IN_READY_o,
   input  logic [EXP_W+MAN_W:0] OP1_i,
   input  logic [EXP_W+MAN_W:0] OP2_i,
   input  logic [TAG_W-1:0]     TAG_i,
   output logic                 OUT_VALID_o,
   input  logic                 OUT_READY_i,
   output logic [EXP_W+MAN_W:0] MUL_o,
   output logic [TAG_W-1:0]     TAG_o,
   output logic                 OVF_o,
   output logic                 UDF_o,
   output logic                 INEXACT_o
);
   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam int E_W  = EXP_W + 2;
   localparam int P_W  = 2 * MAN_W + 2;
   localparam logic [E_W-1:0] BIAS_E = E_W'(fp_bias(EXP_W));

   typedef struct packed {
      logic             sign;
      logic             zero;
      logic [E_W-1:0]   exp;
      logic [MAN_W:0]   sig_a;
      logic [MAN_W:0]   sig_b;
      logic [TAG_W-1:0] tag;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic             zero;
      logic [E_W-1:0]   exp;
      logic [P_W-1:0]   prod;
      logic [TAG_W-1:0] tag;
   } s2_t;

   s1_t               s1_d;
   s1_t               s1_q;
   s2_t               s2_q;
   logic              v1;
   logic              v2;
   logic              v3;
   logic              adv1;
   logic              adv2;
   logic              adv3;
   logic [FP_W-1:0]   rp_res;
   fp_flags_t         rp_flags;
   logic [FP_W-1:0]   mul_q;
   logic [TAG_W-1:0]  tag_q;
   fp_flags_t         flags_q;

   assign adv3       = !v3 || OUT_READY_i;
   assign adv2       = !v2 || adv3;
   assign adv1       = !v1 || adv2;
   assign IN_READY_o = adv1;

   always_comb begin
      s1_d.sign  = OP1_i[FP_W-1] ^ OP2_i[FP_W-1];
      // No subnormals: a zero exponent field flushes the operand.
      s1_d.zero  = (OP1_i[FP_W-2 -: EXP_W] == '0)
                || (OP2_i[FP_W-2 -: EXP_W] == '0);
      s1_d.exp   = {2'b00, OP1_i[FP_W-2 -: EXP_W]}
                 + {2'b00, OP2_i[FP_W-2 -: EXP_W]}
                 - BIAS_E;
      s1_d.sig_a = {1'b1, OP1_i[MAN_W-1:0]};
      s1_d.sig_b = {1'b1, OP2_i[MAN_W-1:0]};
      s1_d.tag   = TAG_i;
   end

   fp_round_pack #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round_pack (
      .sign    (s2_q.sign),
      .zero    (s2_q.zero),
      .exp_sum (s2_q.exp),
      .prod    (s2_q.prod),
      .res     (rp_res),
      .flags   (rp_flags)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
         mul_q   <= '0;
         tag_q   <= '0;
         flags_q <= '0;
      end else begin
         if (adv1) begin
            v1 <= IN_VALID_i;
            if (IN_VALID_i) s1_q <= s1_d;
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               s2_q.sign <= s1_q.sign;
               s2_q.zero <= s1_q.zero;
               s2_q.exp  <= s1_q.exp;
               s2_q.tag  <= s1_q.tag;
               s2_q.prod <= {{(MAN_W+1){1'b0}}, s1_q.sig_a}
                          * {{(MAN_W+1){1'b0}}, s1_q.sig_b};
            end
         end
         if (adv3) begin
            v3 <= v2;
            if (v2) begin
               mul_q   <= rp_res;
               tag_q   <= s2_q.tag;
               flags_q <= rp_flags;
            end
         end
      end
   end

   assign OUT_VALID_o = v3;
   assign MUL_o       = mul_q;
   assign TAG_o       = tag_q;
   assign OVF_o       = flags_q.ovf;
   assign UDF_o       = flags_q.udf;
   assign INEXACT_o   = flags_q.inexact;

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined successor to the combinational FPMUL half-precision multiplier.
- Multiplies two IEEE-style floats of configurable exponent and mantissa width.
- Uses a 3-stage valid/ready pipeline with back-pressure, a sideband tag, and status flags.
- Sits between operand-issue logic and the result writeback of the FP datapath.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width (hidden bit excluded).
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- Derived: FP_W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID_i  in  1  operand pair valid.
- IN_READY_o  out  1  block accepts the pair this cycle.
- OP1_i  in  FP_W  operand 1 {sign, exp, man}.
- OP2_i  in  FP_W  operand 2.
- TAG_i  in  TAG_W  sideband tag, returned unchanged with the result.
- OUT_VALID_o  out  1  result valid.
- OUT_READY_i  in  1  consumer accepts the result.
- MUL_o  out  FP_W  product.
- TAG_o  out  TAG_W  tag of this result.
- OVF_o  out  1  result saturated to infinity.
- UDF_o  out  1  result flushed to zero.
- INEXACT_o  out  1  nonzero bits were discarded.

Behaviour:
- Reset:
  - One clock with RST high clears all stage valid bits.
  - OUT_VALID_o=0, MUL_o=0, TAG_o=0, all flags 0.
  - IN_READY_o=1 in the first cycle after reset.
  - RST mid-operation drops all in-flight results silently.
- Handshake:
  - A transfer occurs when VALID && READY are both high on the rising edge.
  - Stage k advances when !valid_k || ready_{k+1}; stage 3 uses OUT_READY_i as ready_{k+1}.
  - IN_READY_o = !valid1 || ready2, combinational from stage state only, never from IN_VALID_i.
  - While OUT_VALID_o=1 and OUT_READY_i=0, all outputs hold stable.
  - Full throughput: one result per cycle when OUT_READY_i stays high.
  - Latency: 3 cycles from input handshake to OUT_VALID_o, with no stall.
  - Capacity is 3 in-flight operations; results emerge in order.
- Stage 1 (unpack):
  - sign = s1^s2.
  - An exp field of 0 means zero: operand flushed, no subnormal support.
  - Exponent sum: e = e1+e2-BIAS, computed signed at EXP_W+2 bits.
  - Significands {1,man} registered.
- Stage 2 (multiply): (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits.
- Stage 3 (normalise/round/pack):
  - If product MSB is set: shift right 1 and increment e.
  - Round per the optional feature; a rounding carry renormalises and increments e again.
  - Exact or flushed zero: MUL_o = {sign, 0}, no flags.
  - e >= 2^EXP_W-1: MUL_o = {sign, all-ones exp, 0}, OVF_o=1.
  - e <= 0: MUL_o = {sign, 0}, UDF_o=1.
  - INEXACT_o=1 if any discarded product bit is nonzero, or OVF_o or UDF_o is set.
- Inf/NaN operand encodings are treated as ordinary large numbers; they are not special-cased.

Optional Feature:
- FP_MUL_RNE_EN defined: round-to-nearest-even on guard/round/sticky bits.
- FP_MUL_RNE_EN undefined: truncation, bit-identical to the legacy FPMUL.
- INEXACT_o behaves the same in both builds.

Decomposition:
- Package fp_pkg holds:
  - EXP_W/MAN_W defaults and BIAS function.
  - Unpacked struct {sign, exp, man}.
  - INF/ZERO constant builders.
  - Flag struct {ovf, udf, inexact}.
- Natural sub-module: fp_round_pack, the stage-3 normalise, round, overflow/underflow and pack logic.
- fp_round_pack is reusable by a future FP adder.

Test Plan:
- 0x4180 x 0x3A00 (2.75 x 0.75) -> MUL_o=0x4020, no flags, OUT_VALID_o exactly 3 cycles after the handshake.
- 0x3E00x0x3E00 -> 0x4080; 0x3F80x0x3F80 -> 0x4308; 0x1E00x0x2200 -> 0x0480; 0x1E00x0x1E00 -> 0x0000 with UDF_o=1; 0x5D00x0x5D00 -> 0x7C00 with OVF_o=1; 0x4249x0xC266 -> sign bit set.
- 0x3E01x0x3E01 -> 0x4082 with FP_MUL_RNE_EN, 0x4081 without; INEXACT_o=1 in both builds.
- Stream 8 ops with tags 0..7 while OUT_READY_i toggles 1,0,0,1: results and tags appear in order, none lost or duplicated, outputs stable during stalls, IN_READY_o=0 once 3 ops are held.
- RST asserted for 1 cycle with 2 ops in flight -> OUT_VALID_o=0 the next cycle, no stale result ever emitted, IN_READY_o=1.
- Zero operand (0x0000 x 0x7BFF) -> 0x0000, no flags; back-to-back 1 op/cycle at OUT_READY_i=1 -> 1 result/cycle.
